// File: rtl/ysyx_23060332_mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and owner encoding for the IFU/LSU memory arbiter.
package ysyx_23060332_mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e              owner;
        logic                wen;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [MASK_W-1:0]   wmask;
    } req_t;

endpackage

// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side channels; slave is the arbiter view, master the requester/memory view.
interface ysyx_23060332_mem_arbiter_if;
    import ysyx_23060332_mem_arbiter_pkg::*;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_resp_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_resp_rdata;

    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/ysyx_23060332_rr_arb2.sv
// Two-input round-robin arbiter: bit0=IFU, bit1=LSU; i_ptr=0 favours LSU on a tie, i_ptr=1 favours IFU.
module ysyx_23060332_rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    // One-hot grant from the valid pair and tie-break pointer
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_ptr ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Shares one memory port between IFU and LSU: round-robin grant, one access in flight,
// programmable delay from accept to the single-cycle memory strobe.
module ysyx_23060332_mem_arbiter
    import ysyx_23060332_mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_23060332_mem_arbiter_if.slave    bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_rr_ptr, w_rr_ptr_nxt;
    req_t              r_req, w_req_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]        w_valid, w_grant;

    assign w_valid = {bus.lsu_req_valid, bus.ifu_req_valid};

    ysyx_23060332_rr_arb2 u_rr_arb2 (
        .i_valid (w_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // State, latency counter, pointer, request latch and response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_rr_ptr <= 1'b0;
            r_req    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_req    <= w_req_nxt;
            r_rdata  <= w_rdata_nxt;
        end
    end

    // Next-state: accept in IDLE, count down in WAIT, capture read data in ISSUE, release in RESP
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rr_ptr_nxt = r_rr_ptr;
        w_req_nxt    = r_req;
        w_rdata_nxt  = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_grant != 2'b00) begin
                    if (w_grant[1]) begin
                        w_req_nxt.owner = OWN_LSU;
                        w_req_nxt.wen   = bus.lsu_req_wen;
                        w_req_nxt.addr  = bus.lsu_req_addr;
                        w_req_nxt.wdata = bus.lsu_req_wdata;
                        w_req_nxt.wmask = bus.lsu_req_wmask;
                    end else begin
                        w_req_nxt.owner = OWN_IFU;
                        w_req_nxt.wen   = 1'b0;
                        w_req_nxt.addr  = bus.ifu_req_addr;
                        w_req_nxt.wdata = '0;
                        w_req_nxt.wmask = '0;
                    end
                    // Point at the requester that did not win so it takes the next tie
                    w_rr_ptr_nxt = w_grant[1];
                    w_cnt_nxt    = LAT_M1;
                    w_state_nxt  = (LATENCY == 1) ? ST_ISSUE : ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                w_rdata_nxt = r_req.wen ? '0 : bus.mem_rdata;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if ((r_req.owner == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode; memory-side signals are zero except during the single ISSUE cycle
    always_comb begin
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.ifu_resp_rdata = '0;
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_resp_rdata = '0;
        bus.mem_ren        = 1'b0;
        bus.mem_wen        = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.mem_wmask      = '0;
        case (r_state)
            ST_IDLE: begin
                bus.ifu_req_ready = w_grant[0];
                bus.lsu_req_ready = w_grant[1];
            end
            ST_ISSUE: begin
                bus.mem_ren   = ~r_req.wen;
                bus.mem_wen   = r_req.wen;
                bus.mem_addr  = r_req.addr;
                bus.mem_wdata = r_req.wdata;
                bus.mem_wmask = r_req.wmask;
            end
            ST_RESP: begin
                if (r_req.owner == OWN_LSU) begin
                    bus.lsu_resp_valid = 1'b1;
                    bus.lsu_resp_rdata = r_rdata;
                end else begin
                    bus.ifu_resp_valid = 1'b1;
                    bus.ifu_resp_rdata = r_rdata;
                end
            end
            default: begin
                bus.ifu_req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Scoreboard bench: two arbiter instances (LATENCY 1 and 3) driven by directed vectors.
module tb_ysyx_23060332_mem_arbiter;
    import ysyx_23060332_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst1_n;
    logic rst3_n;
    always #5 clk = ~clk;

    ysyx_23060332_mem_arbiter_if if1 ();
    ysyx_23060332_mem_arbiter_if if3 ();

    ysyx_23060332_mem_arbiter #(.LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1));
    ysyx_23060332_mem_arbiter #(.LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3));

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'h0000_0513;
            default:       return a ^ 32'h1234_5678;
        endcase
    endfunction

    assign if1.mem_rdata = mem_model(if1.mem_addr);
    assign if3.mem_rdata = mem_model(if3.mem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_ifu[$];
    logic [31:0] exp_lsu[$];
    int ifu_resp_cnt = 0;
    int lsu_resp_cnt = 0;
    int wen1_cnt     = 0;
    int wen3_cnt     = 0;

    // Scoreboard for the LATENCY=1 instance: push on accept, pop on strobe / response
    always @(negedge clk) begin : sb_mon
        mem_exp_t m;
        logic [31:0] d;
        if (rst1_n) begin
            if (if1.ifu_req_valid || if1.lsu_req_valid)
                check("one_ready", 32'(if1.ifu_req_ready & if1.lsu_req_ready), 32'd0);
            if (if1.ifu_req_valid && if1.ifu_req_ready) begin
                exp_ifu.push_back(mem_model(if1.ifu_req_addr));
                exp_mem.push_back({1'b0, if1.ifu_req_addr, 32'd0, 8'd0});
            end
            if (if1.lsu_req_valid && if1.lsu_req_ready) begin
                exp_lsu.push_back(if1.lsu_req_wen ? 32'd0 : mem_model(if1.lsu_req_addr));
                exp_mem.push_back({if1.lsu_req_wen, if1.lsu_req_addr, if1.lsu_req_wdata, if1.lsu_req_wmask});
            end
            if (if1.mem_wen) wen1_cnt++;
            if (if1.mem_ren || if1.mem_wen) begin
                check("strobe_excl", 32'(if1.mem_ren & if1.mem_wen), 32'd0);
                if (exp_mem.size() == 0) begin
                    check("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    m = exp_mem.pop_front();
                    check("mem_wen", 32'(if1.mem_wen), 32'(m.wen));
                    check("mem_addr", if1.mem_addr, m.addr);
                    check("mem_wdata", if1.mem_wdata, m.wdata);
                    check("mem_wmask", 32'(if1.mem_wmask), 32'(m.wmask));
                end
            end
            if (if1.ifu_resp_valid && if1.ifu_resp_ready) begin
                ifu_resp_cnt++;
                if (exp_ifu.size() == 0) begin
                    check("ifu_resp_unexpected", 32'd1, 32'd0);
                end else begin
                    d = exp_ifu.pop_front();
                    check("ifu_resp_rdata", if1.ifu_resp_rdata, d);
                end
            end
            if (if1.lsu_resp_valid && if1.lsu_resp_ready) begin
                lsu_resp_cnt++;
                if (exp_lsu.size() == 0) begin
                    check("lsu_resp_unexpected", 32'd1, 32'd0);
                end else begin
                    d = exp_lsu.pop_front();
                    check("lsu_resp_rdata", if1.lsu_resp_rdata, d);
                end
            end
        end
    end

    // Store-strobe counter for the LATENCY=3 instance
    always @(negedge clk) begin
        if (if3.mem_wen) wen3_cnt++;
    end

    task automatic idle_if1();
        if1.ifu_req_valid = 1'b0; if1.ifu_req_addr = 32'd0;
        if1.lsu_req_valid = 1'b0; if1.lsu_req_addr = 32'd0; if1.lsu_req_wen = 1'b0;
        if1.lsu_req_wdata = 32'd0; if1.lsu_req_wmask = 8'd0;
    endtask

    task automatic idle_if3();
        if3.ifu_req_valid = 1'b0; if3.ifu_req_addr = 32'd0;
        if3.lsu_req_valid = 1'b0; if3.lsu_req_addr = 32'd0; if3.lsu_req_wen = 1'b0;
        if3.lsu_req_wdata = 32'd0; if3.lsu_req_wmask = 8'd0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int grants[$];
        int exp_order[4];
        exp_order = '{1, 0, 1, 0};
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        idle_if1();
        idle_if3();
        if1.ifu_resp_ready = 1'b1; if1.lsu_resp_ready = 1'b1;
        if3.ifu_resp_ready = 1'b1; if3.lsu_resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'({if1.ifu_req_ready, if1.lsu_req_ready}), 32'd0);
        check("rst_resp_valid", 32'({if1.ifu_resp_valid, if1.lsu_resp_valid}), 32'd0);
        check("rst_strobes", 32'({if1.mem_ren, if1.mem_wen}), 32'd0);
        check("rst_mem_addr", if1.mem_addr, 32'd0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;

        // IFU read, LATENCY=1
        @(posedge clk); #1;
        if1.ifu_req_valid = 1'b1; if1.ifu_req_addr = 32'h8000_0000;
        #1;
        check("ifu_ready", 32'(if1.ifu_req_ready), 32'd1);
        check("lsu_ready_idle", 32'(if1.lsu_req_ready), 32'd0);
        @(posedge clk); #1;
        if1.ifu_req_valid = 1'b0;
        check("ifu_mem_ren", 32'(if1.mem_ren), 32'd1);
        check("ifu_mem_addr", if1.mem_addr, 32'h8000_0000);
        check("ifu_ready_issue", 32'(if1.ifu_req_ready), 32'd0);
        @(posedge clk); #1;
        check("ifu_resp_valid", 32'(if1.ifu_resp_valid), 32'd1);
        check("ifu_rdata", if1.ifu_resp_rdata, 32'h0000_0413);
        check("ifu_mem_ren_off", 32'(if1.mem_ren), 32'd0);
        @(posedge clk); #1;
        check("ifu_resp_done", 32'(if1.ifu_resp_valid), 32'd0);

        // LSU store
        if1.lsu_req_valid = 1'b1; if1.lsu_req_addr = 32'h8000_0010; if1.lsu_req_wen = 1'b1;
        if1.lsu_req_wdata = 32'hDEAD_BEEF; if1.lsu_req_wmask = 8'h0F;
        #1;
        check("st_ready", 32'(if1.lsu_req_ready), 32'd1);
        @(posedge clk); #1;
        idle_if1();
        check("st_mem_wen", 32'(if1.mem_wen), 32'd1);
        check("st_mem_ren", 32'(if1.mem_ren), 32'd0);
        check("st_mem_addr", if1.mem_addr, 32'h8000_0010);
        check("st_mem_wdata", if1.mem_wdata, 32'hDEAD_BEEF);
        check("st_mem_wmask", 32'(if1.mem_wmask), 32'h0000_000F);
        @(posedge clk); #1;
        check("st_resp_valid", 32'(if1.lsu_resp_valid), 32'd1);
        check("st_resp_rdata", if1.lsu_resp_rdata, 32'd0);
        check("st_wen_off", 32'(if1.mem_wen), 32'd0);
        @(posedge clk); #1;
        check("st_resp_done", 32'(if1.lsu_resp_valid), 32'd0);

        // Round-robin from reset with both requesters always valid
        rst1_n = 1'b0;
        @(posedge clk); #1;
        rst1_n = 1'b1;
        if1.ifu_req_valid = 1'b1; if1.ifu_req_addr = 32'h8000_0000;
        if1.lsu_req_valid = 1'b1; if1.lsu_req_addr = 32'h8000_0004;
        for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
            @(negedge clk);
            if (if1.lsu_req_valid && if1.lsu_req_ready) grants.push_back(1);
            else if (if1.ifu_req_valid && if1.ifu_req_ready) grants.push_back(0);
        end
        @(posedge clk); #1;
        idle_if1();
        check("rr_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("rr_order", 32'(grants[i]), 32'(exp_order[i]));
        end
        repeat (4) @(posedge clk);

        // Response stall with the IFU waiting
        #1;
        if1.lsu_req_valid = 1'b1; if1.lsu_req_addr = 32'h8000_0004; if1.lsu_resp_ready = 1'b0;
        #1;
        check("stall_accept", 32'(if1.lsu_req_ready), 32'd1);
        @(posedge clk); #1;
        if1.lsu_req_valid = 1'b0;
        if1.ifu_req_valid = 1'b1; if1.ifu_req_addr = 32'h8000_0000;
        #1;
        check("stall_ifu_blocked_issue", 32'(if1.ifu_req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_resp_valid", 32'(if1.lsu_resp_valid), 32'd1);
            check("stall_rdata", if1.lsu_resp_rdata, 32'h0000_0513);
            check("stall_ifu_blocked", 32'(if1.ifu_req_ready), 32'd0);
        end
        if1.lsu_resp_ready = 1'b1;
        #1;
        check("stall_no_b2b", 32'(if1.ifu_req_ready), 32'd0);
        @(posedge clk); #1;
        check("stall_released", 32'(if1.lsu_resp_valid), 32'd0);
        check("stall_ifu_granted", 32'(if1.ifu_req_ready), 32'd1);
        @(posedge clk); #1;
        idle_if1();
        repeat (4) @(posedge clk);

        // LATENCY=3 load timing
        #1;
        if3.lsu_req_valid = 1'b1; if3.lsu_req_addr = 32'h8000_0008;
        #1;
        check("l3_accept", 32'(if3.lsu_req_ready), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("l3_ready_low", 32'(if3.lsu_req_ready), 32'd0);
            check("l3_mem_ren", 32'(if3.mem_ren), (i == 3) ? 32'd1 : 32'd0);
            check("l3_resp_valid", 32'(if3.lsu_resp_valid), (i == 4) ? 32'd1 : 32'd0);
            if (i == 3) check("l3_mem_addr", if3.mem_addr, 32'h8000_0008);
            if (i == 4) check("l3_rdata", if3.lsu_resp_rdata, 32'h9234_5670);
        end
        idle_if3();
        @(posedge clk); #1;
        check("l3_resp_done", 32'(if3.lsu_resp_valid), 32'd0);

        // Reset during WAIT of a store
        if3.lsu_req_valid = 1'b1; if3.lsu_req_addr = 32'h8000_0020; if3.lsu_req_wen = 1'b1;
        if3.lsu_req_wdata = 32'h1111_2222; if3.lsu_req_wmask = 8'hFF;
        #1;
        check("rw_accept", 32'(if3.lsu_req_ready), 32'd1);
        @(posedge clk); #1;
        idle_if3();
        rst3_n = 1'b0;
        #1;
        check("rw_ctrl_zero", 32'({if3.ifu_req_ready, if3.lsu_req_ready, if3.ifu_resp_valid,
                                   if3.lsu_resp_valid, if3.mem_ren, if3.mem_wen}), 32'd0);
        check("rw_addr_zero", if3.mem_addr, 32'd0);
        check("rw_wdata_zero", if3.mem_wdata, 32'd0);
        check("rw_wmask_zero", 32'(if3.mem_wmask), 32'd0);
        check("rw_rdata_zero", if3.lsu_resp_rdata | if3.ifu_resp_rdata, 32'd0);
        repeat (3) @(posedge clk); #1;
        rst3_n = 1'b1;
        if3.ifu_req_valid = 1'b1; if3.ifu_req_addr = 32'h8000_0000;
        if3.lsu_req_valid = 1'b1; if3.lsu_req_addr = 32'h8000_0008;
        #1;
        check("rw_first_lsu", 32'(if3.lsu_req_ready), 32'd1);
        check("rw_first_not_ifu", 32'(if3.ifu_req_ready), 32'd0);
        @(posedge clk); #1;
        idle_if3();
        repeat (8) @(posedge clk);

        // Final bookkeeping
        check("wen3_pulses", 32'(wen3_cnt), 32'd0);
        check("wen1_pulses", 32'(wen1_cnt), 32'd1);
        check("ifu_resp_count", 32'(ifu_resp_cnt), 32'd4);
        check("lsu_resp_count", 32'(lsu_resp_cnt), 32'd4);
        check("sb_empty", 32'(exp_mem.size() + exp_ifu.size() + exp_lsu.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
